// File: rtl/regn_arb_pkg.sv
// regn_arb_pkg: shared types and width helpers for the shared-register arbiter
package regn_arb_pkg;
  typedef enum logic {IDLE, OWNED} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) if ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int iw_of(input int n);
    return n < 2 ? 1 : clog2(n);
  endfunction
endpackage

// File: rtl/regn_rr_pick.sv
// regn_rr_pick: combinational round-robin picker, first set request at or after ptr
module regn_rr_pick import regn_arb_pkg::*; #(
  parameter int nreq = 4,
  localparam int iw = iw_of(nreq)
) (
  input  logic [nreq-1:0] i_req,
  input  logic [iw-1:0]   i_ptr,
  output logic            o_valid,
  output logic [iw-1:0]   o_idx
);
  localparam int w1 = iw + 1;
  localparam logic [iw:0] n_req = w1'(nreq);
  logic [nreq-1:0] w_rot;
  logic [iw:0]     w_off;
  logic [iw:0]     w_sum;
  always_comb begin
    w_rot = nreq'({i_req, i_req} >> i_ptr);
    w_off = '0;
    o_valid = 1'b0;
    for (int k = nreq - 1; k >= 0; k--) if (w_rot[k]) begin
      o_valid = 1'b1;
      w_off = w1'(k);
    end
    w_sum = {1'b0, i_ptr} + w_off;
    o_idx = w_sum >= n_req ? iw'(w_sum - n_req) : iw'(w_sum);
  end
endmodule

// File: rtl/regn_shared_arbiter.sv
// regn_shared_arbiter: round-robin shared register with lock ownership and hold timeout
module regn_shared_arbiter import regn_arb_pkg::*; #(
  parameter int               width    = 32,
  parameter int               nreq     = 4,
  parameter logic [width-1:0] init     = '0,
  parameter int               max_hold = 0,
  localparam int              iw       = iw_of(nreq)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [nreq-1:0]         REQ,
  input  logic [nreq-1:0]         LOCK,
  input  logic [nreq*width-1:0]   D_IN,
  output logic [width-1:0]        Q_OUT,
  output logic [nreq-1:0]         ACK,
  output logic                    BUSY,
  output logic [iw-1:0]           OWNER,
  output logic                    EVICT
);
  localparam int hw = iw_of(max_hold + 1);
  localparam logic [hw-1:0] h_last = hw'(max_hold > 0 ? max_hold - 1 : 0);
  localparam logic [iw-1:0] last = iw'(nreq - 1);
  localparam logic [nreq-1:0] one = nreq'(1);
  state_t           r_state;
  logic [iw-1:0]    r_ptr;
  logic [hw-1:0]    r_hcnt;
  logic             w_valid;
  logic [iw-1:0]    w_win;
  logic [iw-1:0]    w_sel;
  logic             w_wr;
  logic [width-1:0] w_d [nreq];
  for (genvar g = 0; g < nreq; g++) begin : g_slice
    assign w_d[g] = D_IN[g*width +: width];
  end
  regn_rr_pick #(.nreq(nreq)) u_pick (
    .i_req(REQ),
    .i_ptr(r_ptr),
    .o_valid(w_valid),
    .o_idx(w_win)
  );
  assign BUSY = r_state == OWNED;
  always_comb begin
    w_sel = BUSY ? OWNER : w_win;
    w_wr = BUSY ? REQ[OWNER] : w_valid;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_hcnt <= '0;
      Q_OUT <= init;
      ACK <= '0;
      OWNER <= '0;
      EVICT <= 1'b0;
    end else begin
      ACK <= w_wr ? one << w_sel : '0;
      EVICT <= 1'b0;
      if (w_wr) Q_OUT <= w_d[w_sel];
      if (r_state == IDLE) begin
        if (w_valid) begin
          OWNER <= w_win;
          r_ptr <= w_win == last ? '0 : w_win + 1'b1;
          if (LOCK[w_win]) begin
            r_state <= OWNED;
            r_hcnt <= '0;
          end
        end
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
        if (!LOCK[OWNER]) r_state <= IDLE;
        else if (max_hold > 0 && r_hcnt == h_last) begin
          r_state <= IDLE;
          EVICT <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regn_shared_arbiter.sv
// tb_regn_shared_arbiter: directed and randomized checks against a behavioural model
module tb_regn_shared_arbiter;
  localparam int mh = 4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   lock = '0;
  logic [127:0] d = '0;
  logic [31:0]  q;
  logic [3:0]   ack;
  logic         busy;
  logic [1:0]   owner;
  logic         evict;
  logic [2:0]   req_b = '0;
  logic [2:0]   lock_b = '0;
  logic [23:0]  d_b = '0;
  logic [7:0]   q_b;
  logic [2:0]   ack_b;
  logic         busy_b;
  logic [1:0]   owner_b;
  logic         evict_b;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_q;
  logic [3:0]  m_ack;
  logic        m_owned;
  logic        m_evict;
  int          m_owner;
  int          m_ptr;
  int          m_hold;
  regn_shared_arbiter #(.width(32), .nreq(4), .init(32'hA5), .max_hold(mh)) dut (
    .CLK(clk), .RST(rst), .REQ(req), .LOCK(lock), .D_IN(d),
    .Q_OUT(q), .ACK(ack), .BUSY(busy), .OWNER(owner), .EVICT(evict)
  );
  regn_shared_arbiter #(.width(8), .nreq(3), .init(8'h00), .max_hold(0)) dut_b (
    .CLK(clk), .RST(rst), .REQ(req_b), .LOCK(lock_b), .D_IN(d_b),
    .Q_OUT(q_b), .ACK(ack_b), .BUSY(busy_b), .OWNER(owner_b), .EVICT(evict_b)
  );
  always #5 clk = ~clk;
  task automatic model_step();
    int w;
    if (rst) begin
      m_q = 32'hA5;
      m_ack = '0;
      m_owned = 1'b0;
      m_evict = 1'b0;
      m_owner = 0;
      m_ptr = 0;
      m_hold = 0;
    end else begin
      m_ack = '0;
      m_evict = 1'b0;
      if (!m_owned) begin
        w = -1;
        for (int k = 0; k < 4; k++) if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
        if (w >= 0) begin
          m_q = d[w*32 +: 32];
          m_ack = 4'(1 << w);
          m_owner = w;
          m_ptr = (w + 1) % 4;
          if (lock[w]) begin
            m_owned = 1'b1;
            m_hold = 0;
          end
        end
      end else begin
        if (req[m_owner]) begin
          m_q = d[m_owner*32 +: 32];
          m_ack = 4'(1 << m_owner);
        end
        if (!lock[m_owner]) m_owned = 1'b0;
        else if (m_hold == mh - 1) begin
          m_owned = 1'b0;
          m_evict = 1'b1;
        end
        m_hold++;
      end
    end
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    n_vec++;
    if ({q, ack, busy, owner, evict} !== {32'hA5, 4'b0, 1'b0, 2'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset got q=%h ack=%b busy=%b owner=%0d evict=%b exp q=a5 ack=0000 busy=0 owner=0 evict=0", q, ack, busy, owner, evict);
    end
  endtask
  task automatic test_wrap_np2();
    int e;
    d_b = {8'h32, 8'h31, 8'h30};
    req_b = 3'b010;
    cyc();
    n_vec++;
    if ({ack_b, owner_b} !== {3'b010, 2'd1}) begin
      n_err++;
      $display("FAIL np2_seed got ack=%b owner=%0d exp ack=010 owner=1", ack_b, owner_b);
    end
    req_b = 3'b101;
    for (int i = 0; i < 4; i++) begin
      cyc();
      e = (i % 2 == 0) ? 2 : 0;
      n_vec++;
      if ({owner_b, ack_b, q_b} !== {2'(e), 3'(1 << e), 8'(8'h30 + e)}) begin
        n_err++;
        $display("FAIL np2_wrap step=%0d got owner=%0d ack=%b q=%h exp owner=%0d", i, owner_b, ack_b, q_b, e);
      end
    end
    req_b = '0;
    cyc();
  endtask
  task automatic test_round_robin();
    logic [3:0] ea [5];
    ea = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) d[i*32 +: 32] = 32'(i + 1);
    req = 4'hF;
    lock = '0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_vec++;
      if ({ack, q, busy} !== {ea[i], 32'(i % 4 + 1), 1'b0}) begin
        n_err++;
        $display("FAIL round_robin step=%0d got ack=%b q=%h exp ack=%b q=%h", i, ack, q, ea[i], i % 4 + 1);
      end
      n_vec++;
      if ({q, ack, busy, owner, evict} !== {m_q, m_ack, m_owned, m_owner[1:0], m_evict}) begin
        n_err++;
        $display("FAIL rr_model step=%0d got q=%h ack=%b exp q=%h ack=%b", i, q, ack, m_q, m_ack);
      end
    end
    req = '0;
    cyc();
  endtask
  task automatic test_lock();
    d[0 +: 32] = 32'h77;
    req = 4'b0101;
    lock = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      d[64 +: 32] = 32'(32'h10 + i);
      if (i == 2) lock = '0;
      cyc();
      n_vec++;
      if ({q, ack, busy, owner} !== {32'(32'h10 + i), 4'b0100, 1'(i < 2), 2'd2}) begin
        n_err++;
        $display("FAIL lock_write step=%0d got q=%h ack=%b busy=%b owner=%0d", i, q, ack, busy, owner);
      end
      n_vec++;
      if ({q, ack, busy, owner, evict} !== {m_q, m_ack, m_owned, m_owner[1:0], m_evict}) begin
        n_err++;
        $display("FAIL lock_model step=%0d got q=%h ack=%b busy=%b exp q=%h ack=%b busy=%b", i, q, ack, busy, m_q, m_ack, m_owned);
      end
    end
    req = 4'b0001;
    cyc();
    n_vec++;
    if ({ack, q, owner, busy} !== {4'b0001, 32'h77, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL lock_release got ack=%b q=%h owner=%0d exp ack=0001 q=77 owner=0", ack, q, owner);
    end
    req = '0;
    cyc();
  endtask
  task automatic test_timeout();
    int n_a1;
    int n_ev;
    n_a1 = 0;
    n_ev = 0;
    d[96 +: 32] = 32'h333;
    req = 4'b1010;
    lock = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      d[32 +: 32] = 32'(32'h200 + i);
      cyc();
      n_a1 += int'(ack[1]);
      n_ev += int'(evict);
      n_vec++;
      if ({q, ack, busy, owner, evict} !== {m_q, m_ack, m_owned, m_owner[1:0], m_evict}) begin
        n_err++;
        $display("FAIL timeout_model step=%0d got q=%h ack=%b busy=%b evict=%b exp q=%h ack=%b busy=%b evict=%b", i, q, ack, busy, evict, m_q, m_ack, m_owned, m_evict);
      end
    end
    n_vec++;
    if ({n_a1, n_ev, 31'b0, busy} !== {32'd5, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL timeout_counts got acks=%0d evicts=%0d busy=%b exp acks=5 evicts=1 busy=0", n_a1, n_ev, busy);
    end
    cyc();
    n_vec++;
    if ({ack, q, owner, evict} !== {4'b1000, 32'h333, 2'd3, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_next got ack=%b q=%h owner=%0d evict=%b exp ack=1000 q=333 owner=3", ack, q, owner, evict);
    end
    req = '0;
    lock = '0;
    cyc();
    cyc();
  endtask
  task automatic test_reset_mid_lock();
    d[0 +: 32] = 32'h55;
    req = 4'b0001;
    lock = 4'b0001;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    n_vec++;
    if ({q, ack, busy, owner, evict} !== {32'hA5, 4'b0, 1'b0, 2'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid_lock got q=%h ack=%b busy=%b owner=%0d evict=%b", q, ack, busy, owner, evict);
    end
    rst = 1'b0;
    req = 4'b1001;
    lock = '0;
    cyc();
    n_vec++;
    if ({ack, owner, q} !== {4'b0001, 2'd0, 32'h55}) begin
      n_err++;
      $display("FAIL reset_ptr got ack=%b owner=%0d q=%h exp ack=0001 owner=0 q=55", ack, owner, q);
    end
    req = '0;
    cyc();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 39) == 0;
      req = 4'($urandom);
      lock = 4'($urandom) | 4'($urandom);
      for (int k = 0; k < 4; k++) d[k*32 +: 32] = $urandom;
      cyc();
      n_vec++;
      if ({q, ack, busy, owner, evict} !== {m_q, m_ack, m_owned, m_owner[1:0], m_evict}) begin
        n_err++;
        $display("FAIL random step=%0d got q=%h ack=%b busy=%b owner=%0d evict=%b exp q=%h ack=%b busy=%b owner=%0d evict=%b", i, q, ack, busy, owner, evict, m_q, m_ack, m_owned, m_owner, m_evict);
      end
    end
    rst = 1'b0;
    req = '0;
    lock = '0;
    cyc();
  endtask
  initial begin
    test_reset();
    test_wrap_np2();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
